// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the 4-way round-robin select-mux arbiter.
//   N_REQ      : number of requesters sharing the mux tree
//   idx_t      : requester index, doubles as the mux-tree select {s1,s0}
//   state_t    : arbiter FSM state
//   idx_onehot : converts an index into a one-hot grant vector
package mux4_arb_pkg;

    localparam int N_REQ = 4;

    typedef logic [1:0] idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] idx_onehot(input idx_t idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational first-set search over a 4-bit request vector.
// The search starts at 'start' and walks upward with wrap (start, start+1, ... mod 4).
// When excl_en is set, the index 'excl' is skipped.
//   req     in   4  request vector
//   start   in   2  first index examined
//   excl_en in   1  enable exclusion of 'excl'
//   excl    in   2  index to skip
//   found   out  1  a qualifying request exists
//   idx     out  2  index of the first qualifying request (== start when none)
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  idx_t             start,
    input  logic             excl_en,
    input  idx_t             excl,
    output logic             found,
    output idx_t             idx
);

    idx_t cand;

    // NOTE: every output and temporary gets a value before the loop so that no
    // path leaves a variable unassigned, which would infer a latch.
    always_comb begin
        found = 1'b0;
        idx   = start;
        cand  = start;
        for (int i = 0; i < N_REQ; i++) begin
            // 2-bit addition wraps 3 -> 0 on its own.
            cand = start + 2'(i);
            if (!found && req[cand] && !(excl_en && (cand == excl))) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_select_arbiter.sv
// Round-robin arbiter sharing one 4:1 select-mux tree between four requesters.
// The owner keeps the grant while it requests, up to MAX_HOLD consecutive cycles
// when someone else is waiting. All outputs are registered (one cycle latency).
//   clk        in   1  rising-edge clock
//   rst_n      in   1  synchronous active-low reset
//   req        in   4  request vector, bit i = requester i
//   gnt        out  4  one-hot grant, or zero
//   gnt_valid  out  1  gnt is non-zero
//   sel        out  2  owner index {s1,s0}; holds the last owner while idle
module mux4_select_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [1:0]       sel
);

    // With no hold limit the counter simply saturates at its maximum.
    localparam logic [CNT_W-1:0] HOLD_LIMIT =
        (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD);

    state_t           state_q, state_d;
    idx_t             owner_q, owner_d;
    idx_t             ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             gnt_valid_q, gnt_valid_d;

    idx_t pick_start;
    logic pick_excl_en;
    logic pick_found;
    idx_t pick_idx;

    // From IDLE search from ptr; while granted search past the owner and skip it,
    // so pick_found also means "another requester is pending".
    assign pick_start   = (state_q == IDLE) ? ptr_q : owner_q + 2'd1;
    assign pick_excl_en = (state_q == GRANT);

    rr_pick4 u_pick (
        .req     (req),
        .start   (pick_start),
        .excl_en (pick_excl_en),
        .excl    (owner_q),
        .found   (pick_found),
        .idx     (pick_idx)
    );

    always_comb begin
        logic take;
        logic release_all;

        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        take        = 1'b0;
        release_all = 1'b0;

        unique case (state_q)
            IDLE: begin
                take = pick_found;
            end
            GRANT: begin
                if (!req[owner_q]) begin
                    take        = pick_found;
                    release_all = !pick_found;
                end else if ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_LIMIT) && pick_found) begin
                    take = 1'b1;
                end else if (hold_cnt_q != HOLD_LIMIT) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                release_all = 1'b1;
            end
        endcase

        if (take) begin
            state_d     = GRANT;
            owner_d     = pick_idx;
            ptr_d       = pick_idx + 2'd1;
            hold_cnt_d  = CNT_W'(1);
            gnt_d       = idx_onehot(pick_idx);
            gnt_valid_d = 1'b1;
        end else if (release_all) begin
            // owner_q is kept so sel stays on the last owner while idle.
            state_d     = IDLE;
            hold_cnt_d  = '0;
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
        end
    end

    // NOTE: reset is sampled only on the clock edge (synchronous); all state
    // updates use non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign sel       = owner_q;

endmodule

// File: tb/tb_mux4_select_arbiter.sv
// Directed self-checking bench for mux4_select_arbiter (MAX_HOLD=8, CNT_W=4).
// Inputs change 1 ns after each rising edge; outputs are checked at that point.
module tb_mux4_select_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] sel;

    int n_cmp = 0;
    int n_err = 0;

    mux4_select_arbiter #(
        .MAX_HOLD (8),
        .CNT_W    (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .sel       (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        tick();
        tick();
        n_cmp++;
        if ({gnt, gnt_valid, sel} !== {4'b0000, 1'b0, 2'd0}) begin
            n_err++;
            $display("FAIL reset_hold: got gnt=%b v=%b sel=%0d, want gnt=0000 v=0 sel=0", gnt, gnt_valid, sel);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if ({gnt, gnt_valid, sel} !== {4'b0001, 1'b1, 2'd0}) begin
            n_err++;
            $display("FAIL reset_first_grant: got gnt=%b v=%b sel=%0d, want gnt=0001 v=1 sel=0", gnt, gnt_valid, sel);
        end
        req = 4'b0000;
        tick();
        n_cmp++;
        if ({gnt, gnt_valid, sel} !== {4'b0000, 1'b0, 2'd0}) begin
            n_err++;
            $display("FAIL reset_release: got gnt=%b v=%b sel=%0d, want gnt=0000 v=0 sel=0", gnt, gnt_valid, sel);
        end
    endtask

    // Idle, ptr=1 on entry.
    task automatic test_single();
        req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({gnt, gnt_valid, sel} !== {4'b0100, 1'b1, 2'd2}) begin
                n_err++;
                $display("FAIL single_hold[%0d]: got gnt=%b v=%b sel=%0d, want gnt=0100 v=1 sel=2", i, gnt, gnt_valid, sel);
            end
        end
        req = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({gnt, gnt_valid, sel} !== {4'b0000, 1'b0, 2'd2}) begin
                n_err++;
                $display("FAIL single_idle_sel[%0d]: got gnt=%b v=%b sel=%0d, want gnt=0000 v=0 sel=2", i, gnt, gnt_valid, sel);
            end
        end
    endtask

    // Idle, ptr=3 on entry: search 3,0 picks 0.
    task automatic test_handoff();
        req = 4'b0001;
        tick();
        n_cmp++;
        if ({gnt, gnt_valid, sel} !== {4'b0001, 1'b1, 2'd0}) begin
            n_err++;
            $display("FAIL handoff_owner0: got gnt=%b v=%b sel=%0d, want gnt=0001 v=1 sel=0", gnt, gnt_valid, sel);
        end
        req = 4'b0110;
        tick();
        n_cmp++;
        if ({gnt, gnt_valid, sel} !== {4'b0010, 1'b1, 2'd1}) begin
            n_err++;
            $display("FAIL handoff_switch: got gnt=%b v=%b sel=%0d, want gnt=0010 v=1 sel=1", gnt, gnt_valid, sel);
        end
        req = 4'b0000;
        tick();
        n_cmp++;
        if ({gnt, gnt_valid, sel} !== {4'b0000, 1'b0, 2'd1}) begin
            n_err++;
            $display("FAIL handoff_idle: got gnt=%b v=%b sel=%0d, want gnt=0000 v=0 sel=1", gnt, gnt_valid, sel);
        end
    endtask

    // Idle, ptr=2 on entry: search 2,3,0 picks 0.
    task automatic test_hold_limit();
        req = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++;
            if ({gnt, sel} !== {4'b0001, 2'd0}) begin
                n_err++;
                $display("FAIL hold_first[%0d]: got gnt=%b sel=%0d, want gnt=0001 sel=0", i, gnt, sel);
            end
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++;
            if ({gnt, sel} !== {4'b0010, 2'd1}) begin
                n_err++;
                $display("FAIL hold_second[%0d]: got gnt=%b sel=%0d, want gnt=0010 sel=1", i, gnt, sel);
            end
        end
        tick();
        n_cmp++;
        if ({gnt, sel} !== {4'b0001, 2'd0}) begin
            n_err++;
            $display("FAIL hold_back: got gnt=%b sel=%0d, want gnt=0001 sel=0", gnt, sel);
        end
        req = 4'b0000;
        tick();
    endtask

    // Idle, ptr=1 on entry. A lone owner saturates at 8, so a late arrival
    // forces a switch on the very next edge.
    task automatic test_saturate();
        req = 4'b0001;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_cmp++;
            if ({gnt, sel} !== {4'b0001, 2'd0}) begin
                n_err++;
                $display("FAIL sat_alone[%0d]: got gnt=%b sel=%0d, want gnt=0001 sel=0", i, gnt, sel);
            end
        end
        req = 4'b0101;
        tick();
        n_cmp++;
        if ({gnt, sel} !== {4'b0100, 2'd2}) begin
            n_err++;
            $display("FAIL sat_switch: got gnt=%b sel=%0d, want gnt=0100 sel=2", gnt, sel);
        end
        req = 4'b0000;
        tick();
    endtask

    // Idle, ptr=3 on entry.
    task automatic test_wrap();
        req = 4'b1000;
        tick();
        n_cmp++;
        if ({gnt, sel} !== {4'b1000, 2'd3}) begin
            n_err++;
            $display("FAIL wrap_owner3: got gnt=%b sel=%0d, want gnt=1000 sel=3", gnt, sel);
        end
        req = 4'b0101;
        tick();
        n_cmp++;
        if ({gnt, sel} !== {4'b0001, 2'd0}) begin
            n_err++;
            $display("FAIL wrap_switch: got gnt=%b sel=%0d, want gnt=0001 sel=0", gnt, sel);
        end
        req = 4'b0000;
        tick();
        // ptr must now be 1, so {0,1} both requesting from idle picks 1.
        req = 4'b0011;
        tick();
        n_cmp++;
        if ({gnt, sel} !== {4'b0010, 2'd1}) begin
            n_err++;
            $display("FAIL wrap_ptr: got gnt=%b sel=%0d, want gnt=0010 sel=1", gnt, sel);
        end
        req = 4'b0000;
        tick();
    endtask

    // Idle, ptr=2 on entry: owner 2 leaves ptr=3, which reset must clear.
    task automatic test_mid_reset();
        req = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({gnt, sel} !== {4'b0100, 2'd2}) begin
                n_err++;
                $display("FAIL midrst_owner[%0d]: got gnt=%b sel=%0d, want gnt=0100 sel=2", i, gnt, sel);
            end
        end
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({gnt, gnt_valid, sel} !== {4'b0000, 1'b0, 2'd0}) begin
            n_err++;
            $display("FAIL midrst_clear: got gnt=%b v=%b sel=%0d, want gnt=0000 v=0 sel=0", gnt, gnt_valid, sel);
        end
        rst_n = 1'b1;
        req   = 4'b1001;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++;
            if ({gnt, gnt_valid, sel} !== {4'b0001, 1'b1, 2'd0}) begin
                n_err++;
                $display("FAIL midrst_regrant[%0d]: got gnt=%b v=%b sel=%0d, want gnt=0001 v=1 sel=0", i, gnt, gnt_valid, sel);
            end
        end
        tick();
        n_cmp++;
        if ({gnt, sel} !== {4'b1000, 2'd3}) begin
            n_err++;
            $display("FAIL midrst_limit: got gnt=%b sel=%0d, want gnt=1000 sel=3", gnt, sel);
        end
        req = 4'b0000;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        #1;
        test_reset();
        test_single();
        test_handoff();
        test_hold_limit();
        test_saturate();
        test_wrap();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
